// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control path
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BR     = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control <-> datapath/ALU/memory signal bundle
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zero_ext;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, imm_zero_ext, pc_src, pc_en,
           ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, imm_zero_ext, pc_src, pc_en,
           ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, illegal, state
  );
endinterface

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - maps (state, latched op, latched funct) to ALU code
module mips_alu_decode
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_imm_zero_ext,
  output logic       o_funct_valid
);

  logic [3:0] w_fn_alu;
  logic       w_fn_valid;

  always_comb begin
    w_fn_alu   = ALU_AND;
    w_fn_valid = 1'b1;
    case (i_funct)
      FN_ADD:  w_fn_alu = ALU_ADD;
      FN_SUB:  w_fn_alu = ALU_SUB;
      FN_AND:  w_fn_alu = ALU_AND;
      FN_OR:   w_fn_alu = ALU_OR;
      FN_NOR:  w_fn_alu = ALU_NOR;
      FN_SLT:  w_fn_alu = ALU_SLT;
      default: w_fn_valid = 1'b0;
    endcase
  end

  // ALU_WB re-decodes the latched funct so the code stays stable through writeback
  always_comb begin
    o_alu_control  = ALU_AND;
    o_imm_zero_ext = 1'b0;
    o_funct_valid  = w_fn_valid;
    case (i_state)
      S_FETCH, S_DECODE, S_MEM_ADDR: o_alu_control = ALU_ADD;
      S_BRANCH:                      o_alu_control = ALU_SUB;
      S_EXECUTE, S_ALU_WB:           o_alu_control = w_fn_alu;
      S_IMM_EXEC: begin
        case (i_op)
          OP_ADDI: o_alu_control = ALU_ADD;
          OP_SLTI: o_alu_control = ALU_SLT;
          OP_ANDI: begin o_alu_control = ALU_AND; o_imm_zero_ext = 1'b1; end
          OP_ORI:  begin o_alu_control = ALU_OR;  o_imm_zero_ext = 1'b1; end
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
)(
  input  logic                           clk,
  input  logic                           rst_n,
  mips_multicycle_control_if.master      bus
);

  state_t     r_state, w_next;
  logic [5:0] r_op, r_funct;

  logic [3:0] w_alu_control;
  logic       w_imm_zero_ext, w_funct_valid;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic       w_pc_en, w_ir_write, w_iord, w_mem_read, w_mem_write;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal;

  mips_alu_decode u_alu_decode (
    .i_state        (r_state),
    .i_op           (r_op),
    .i_funct        (r_funct),
    .o_alu_control  (w_alu_control),
    .o_imm_zero_ext (w_imm_zero_ext),
    .o_funct_valid  (w_funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= state_t'(RESET_STATE);
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= bus.opcode;
        r_funct <= bus.funct;
      end
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_REG;
    w_pc_src     = PCSRC_ALU;
    w_pc_en      = 1'b0;
    w_ir_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
        w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Opcode is taken live from IR here; it is latched on the same edge
        w_alu_src_b = SRCB_BR;
        case (bus.opcode)
          OP_RTYPE:                          w_next = S_EXECUTE;
          OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IMM_EXEC;
          OP_J:                              w_next = S_JUMP;
          default:                           w_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = SRCA_REG;
        w_alu_src_b = SRCB_IMM;
        w_next      = (r_op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        w_next     = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_next      = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        w_alu_src_a = SRCA_REG;
        if (w_funct_valid) w_next = S_ALU_WB;
        else               w_illegal = 1'b1;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = SRCA_REG;
        w_pc_src    = PCSRC_ALUOUT;
        w_pc_en     = (r_op == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      S_IMM_EXEC: begin
        w_alu_src_a = SRCA_REG;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_IMM_WB;
      end
      S_IMM_WB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src = PCSRC_JUMP;
        w_pc_en  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset gates every strobe combinationally so an abort cannot leak a write
  assign bus.alu_control  = rst_n ? w_alu_control : 4'd0;
  assign bus.alu_src_a    = rst_n & w_alu_src_a;
  assign bus.alu_src_b    = rst_n ? w_alu_src_b : 2'd0;
  assign bus.imm_zero_ext = rst_n & w_imm_zero_ext;
  assign bus.pc_src       = rst_n ? w_pc_src : 2'd0;
  assign bus.pc_en        = rst_n & w_pc_en;
  assign bus.ir_write     = rst_n & w_ir_write;
  assign bus.iord         = rst_n & w_iord;
  assign bus.mem_read     = rst_n & w_mem_read;
  assign bus.mem_write    = rst_n & w_mem_write;
  assign bus.reg_write    = rst_n & w_reg_write;
  assign bus.reg_dst      = rst_n & w_reg_dst;
  assign bus.mem_to_reg   = rst_n & w_mem_to_reg;
  assign bus.illegal      = rst_n & w_illegal;
  assign bus.state        = rst_n ? r_state : 4'd0;

endmodule
